// File: rtl/apb_req_arbiter_pkg.sv
// Shared types and defaults for the multi-requester APB master.
// The request latch is sized by the APB bus defaults below.
package apb_req_arbiter_pkg;

   localparam int APB_ADDR_W  = 32;
   localparam int APB_DATA_W  = 32;
   localparam int TIMEOUT_DEF = 16;
   localparam int TMO_CNT_W   = $clog2(TIMEOUT_DEF);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } apb_state_e;

   typedef struct packed {
      logic                  write;
      logic [APB_ADDR_W-1:0] addr;
      logic [APB_DATA_W-1:0] wdata;
   } apb_req_t;

   // Wrapping increment of a requester index.
   function automatic int rr_next(input int idx, input int n);
      return (idx >= n - 1) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/apb_req_arbiter_rr.sv
// Round-robin picker: first requester at or after the pointer, wrapping.
// The pointer moves to one past the served index when en pulses.
module apb_req_arbiter_rr
   import apb_req_arbiter_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  req,
   input  logic          en,
   input  logic [IW-1:0] cur_idx,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx,
   output logic          any
);

   logic [IW-1:0] ptr_r;

   // Rotated priority search starting at the pointer.
   always_comb begin
      grant     = {N{1'b0}};
      grant_idx = {IW{1'b0}};
      any       = 1'b0;
      for (int i = 0; i < N; i++) begin
         int  j;
         logic hit;
         j   = int'(ptr_r) + i;
         j   = (j >= N) ? j - N : j;
         hit = req[j] && !any;
         grant[j]  = hit;
         grant_idx = hit ? IW'(j) : grant_idx;
         any       = any | hit;
      end
   end

   // Pointer register, advanced once per completed transfer.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_r <= {IW{1'b0}};
      end else if (en) begin
         ptr_r <= IW'(rr_next(int'(cur_idx), N));
      end else begin
         ptr_r <= ptr_r;
      end
   end

endmodule

// File: rtl/apb_req_arbiter.sv
// Multi-requester APB master: round-robin grant, one SETUP/ACCESS transfer
// at a time, with PREADY wait states and a forced-error timeout.
module apb_req_arbiter
   import apb_req_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = APB_ADDR_W,
   parameter int DATA_WIDTH = APB_DATA_W,
   parameter int NUM_REQ    = 4,
   parameter int TIMEOUT    = TIMEOUT_DEF
) (
   input  logic                          PCLK,
   input  logic                          PRESET,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0]            req_write,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic [DATA_WIDTH-1:0]         rsp_rdata,
   output logic                          rsp_err,
   output logic                          PSEL,
   output logic                          PENABLE,
   output logic [ADDR_WIDTH-1:0]         PADDR,
   output logic                          PWRITE,
   output logic [DATA_WIDTH-1:0]         PWDATA,
   input  logic [DATA_WIDTH-1:0]         PRDATA,
   input  logic                          PREADY,
   input  logic                          PSLVERR
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(TIMEOUT);

   apb_state_e           state_r, state_s;
   apb_req_t             req_r, req_sel_s;
   logic [IDX_W-1:0]     gidx_r, grant_idx_s;
   logic [NUM_REQ-1:0]   grant_s;
   logic                 any_s;
   logic                 adv_s;
   logic                 tmo_s;
   logic [CNT_W-1:0]     cnt_r;
   logic                 psel_r, penable_r, rsp_err_r;
   logic [NUM_REQ-1:0]   rsp_valid_r;
   logic [DATA_WIDTH-1:0] rsp_rdata_r;

   apb_req_arbiter_rr #(.N(NUM_REQ), .IW(IDX_W)) u_rr (
      .clk       (PCLK),
      .rst       (PRESET),
      .req       (req_valid),
      .en        (adv_s),
      .cur_idx   (gidx_r),
      .grant     (grant_s),
      .grant_idx (grant_idx_s),
      .any       (any_s)
   );

   assign adv_s = (state_r == RESP);
   assign tmo_s = (cnt_r == CNT_W'(TIMEOUT - 1));

   // The accept pulse must coincide with the IDLE cycle that sees req_valid,
   // so it is the only output decoded combinationally.
   assign req_ready = (state_r == IDLE && !PRESET) ? grant_s : {NUM_REQ{1'b0}};

   assign PSEL      = psel_r;
   assign PENABLE   = penable_r;
   assign PADDR     = req_r.addr;
   assign PWRITE    = req_r.write;
   assign PWDATA    = req_r.wdata;
   assign rsp_valid = rsp_valid_r;
   assign rsp_rdata = rsp_rdata_r;
   assign rsp_err   = rsp_err_r;

   // Fields of the currently winning requester.
   always_comb begin
      req_sel_s.write = req_write[grant_idx_s];
      req_sel_s.addr  = req_addr[int'(grant_idx_s)*ADDR_WIDTH +: ADDR_WIDTH];
      req_sel_s.wdata = req_wdata[int'(grant_idx_s)*DATA_WIDTH +: DATA_WIDTH];
   end

   // Next-state decode.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (any_s) state_s = SETUP;
            else       state_s = IDLE;
         end
         SETUP:  state_s = ACCESS;
         ACCESS: begin
            if (PREADY || tmo_s) state_s = RESP;
            else                 state_s = ACCESS;
         end
         RESP:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // State, request latch, wait counter and registered APB/response outputs.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_r     <= IDLE;
         req_r       <= '0;
         gidx_r      <= {IDX_W{1'b0}};
         cnt_r       <= {CNT_W{1'b0}};
         psel_r      <= 1'b0;
         penable_r   <= 1'b0;
         rsp_valid_r <= {NUM_REQ{1'b0}};
         rsp_rdata_r <= {DATA_WIDTH{1'b0}};
         rsp_err_r   <= 1'b0;
      end else begin
         state_r <= state_s;
         case (state_r)
            IDLE: begin
               if (any_s) begin
                  req_r  <= req_sel_s;
                  gidx_r <= grant_idx_s;
                  psel_r <= 1'b1;
               end else begin
                  psel_r <= 1'b0;
               end
               penable_r <= 1'b0;
            end
            SETUP: begin
               penable_r <= 1'b1;
               cnt_r     <= {CNT_W{1'b0}};
            end
            ACCESS: begin
               if (PREADY) begin
                  psel_r      <= 1'b0;
                  penable_r   <= 1'b0;
                  rsp_valid_r <= NUM_REQ'(1'b1) << gidx_r;
                  rsp_rdata_r <= req_r.write ? {DATA_WIDTH{1'b0}} : PRDATA;
                  rsp_err_r   <= PSLVERR;
               end else if (tmo_s) begin
                  psel_r      <= 1'b0;
                  penable_r   <= 1'b0;
                  rsp_valid_r <= NUM_REQ'(1'b1) << gidx_r;
                  rsp_rdata_r <= {DATA_WIDTH{1'b0}};
                  rsp_err_r   <= 1'b1;
               end else begin
                  cnt_r <= cnt_r + CNT_W'(1);
               end
            end
            RESP: begin
               rsp_valid_r <= {NUM_REQ{1'b0}};
               rsp_rdata_r <= {DATA_WIDTH{1'b0}};
               rsp_err_r   <= 1'b0;
            end
            default: begin
               psel_r    <= 1'b0;
               penable_r <= 1'b0;
            end
         endcase
      end
   end

endmodule
